// File: rtl/stat_scan_pkg.sv
// -----------------------------------------------------------------------------
// stat_scan_pkg
// Shared definitions for the cycle-statistics scan controller:
//   - RAM_AW / RAM_DW : geometry of the external cycle RAM read port
//   - CNT_W           : width of the entry-count field stored at RAM[0]
//   - scan_state_t    : FSM state encoding of stat_scan_ctrl
//   - clamp_count()   : limits a raw entry count to the last scannable address
// -----------------------------------------------------------------------------
package stat_scan_pkg;

    localparam int RAM_AW = 6;
    localparam int RAM_DW = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CNT   = 3'd1,
        CAP_CNT  = 3'd2,
        RD_ENT   = 3'd3,
        CAP_ENT  = 3'd4,
        HOST_RD  = 3'd5,
        HOST_CAP = 3'd6,
        DONE     = 3'd7
    } scan_state_t;

    function automatic logic [CNT_W-1:0] clamp_count(
        input logic [CNT_W-1:0] raw,
        input logic [CNT_W-1:0] limit
    );
        return (raw > limit) ? limit : raw;
    endfunction

endpackage

// File: rtl/stat_scan_ctrl.sv
// -----------------------------------------------------------------------------
// stat_scan_ctrl
// After every revolution (i_scan_start) this controller walks the cycle RAM:
// RAM[0][7:0] holds the number of captured intervals N, RAM[1..N] the interval
// lengths. It reports N together with the minimum and maximum interval. The
// same RAM read port is shared with a host, which is served either from IDLE
// or squeezed in between two scanned entries.
//
// Optional build feature (macro CYCLE_FAULT_CHK_EN):
//   defined   -> o_cycle_fault flags a wrong entry count or an out-of-range
//                interval, recomputed at the end of every scan
//   undefined -> o_cycle_fault is constant 0, threshold inputs are ignored
//
// Ports
//   i_clk_50m, i_rst_n        clock, asynchronous active-low reset
//   i_scan_start              pulse: start a scan (ignored + o_scan_miss if busy)
//   i_host_req/i_host_addr    host read request (level) and address
//   o_host_ack/o_host_rdata   ack pulse and held read data
//   o_ram_raddr/o_ram_ren     RAM read port, i_ram_rdata valid one cycle later
//   i_cyc_lo/i_cyc_hi         allowed interval range (fault check)
//   i_expect_num              expected entry count (fault check)
//   o_opto_num/o_min_cycle/o_max_cycle   results of the last completed scan
//   o_scan_busy, o_scan_done, o_scan_miss, o_cycle_fault   status
// -----------------------------------------------------------------------------
module stat_scan_ctrl
    import stat_scan_pkg::*;
#(
    parameter int P_LAST_ENTRY = 59
) (
    input  logic              i_clk_50m,
    input  logic              i_rst_n,
    input  logic              i_scan_start,
    input  logic              i_host_req,
    input  logic [RAM_AW-1:0] i_host_addr,
    output logic              o_host_ack,
    output logic [RAM_DW-1:0] o_host_rdata,
    output logic [RAM_AW-1:0] o_ram_raddr,
    output logic              o_ram_ren,
    input  logic [RAM_DW-1:0] i_ram_rdata,
    input  logic [RAM_DW-1:0] i_cyc_lo,
    input  logic [RAM_DW-1:0] i_cyc_hi,
    input  logic [CNT_W-1:0]  i_expect_num,
    output logic [CNT_W-1:0]  o_opto_num,
    output logic [RAM_DW-1:0] o_min_cycle,
    output logic [RAM_DW-1:0] o_max_cycle,
    output logic              o_scan_busy,
    output logic              o_scan_done,
    output logic              o_scan_miss,
    output logic              o_cycle_fault
);

    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(P_LAST_ENTRY);
    localparam logic [RAM_AW-1:0] FIRST_ENTRY = RAM_AW'(1);

    scan_state_t       state_reg,       state_next;
    logic              scan_active_reg, scan_active_next;
    logic              start_pend_reg,  start_pend_next;
    logic [CNT_W-1:0]  raw_cnt_reg,     raw_cnt_next;
    logic [RAM_AW-1:0] last_idx_reg,    last_idx_next;
    logic [RAM_AW-1:0] idx_reg,         idx_next;
    logic [RAM_DW-1:0] run_min_reg,     run_min_next;
    logic [RAM_DW-1:0] run_max_reg,     run_max_next;
    logic [RAM_AW-1:0] raddr_reg,       raddr_next;
    logic              ren_reg,         ren_next;
    logic              host_ack_reg,    host_ack_next;
    logic [RAM_DW-1:0] host_rdata_reg,  host_rdata_next;
    logic [CNT_W-1:0]  opto_num_reg,    opto_num_next;
    logic [RAM_DW-1:0] min_out_reg,     min_out_next;
    logic [RAM_DW-1:0] max_out_reg,     max_out_next;
    logic              scan_done_reg,   scan_done_next;
    logic              scan_miss_reg,   scan_miss_next;
    logic [CNT_W-1:0]  clamped_cnt;
    logic              host_serve;

`ifdef CYCLE_FAULT_CHK_EN
    logic              range_err_reg,   range_err_next;
    logic              fault_reg,       fault_next;
`else
    logic              unused_thresholds;
    assign unused_thresholds = ^{i_cyc_lo, i_cyc_hi, i_expect_num};
`endif

    // The host is not served in the cycle right after an ack: a host that
    // still holds its request for one cycle must not get a second read.
    assign host_serve  = i_host_req && !host_ack_reg;
    assign clamped_cnt = clamp_count(i_ram_rdata[CNT_W-1:0], LAST_CNT);

    always_comb begin
        state_next       = state_reg;
        scan_active_next = scan_active_reg;
        start_pend_next  = start_pend_reg;
        raw_cnt_next     = raw_cnt_reg;
        last_idx_next    = last_idx_reg;
        idx_next         = idx_reg;
        run_min_next     = run_min_reg;
        run_max_next     = run_max_reg;
        raddr_next       = raddr_reg;
        ren_next         = 1'b0;
        host_ack_next    = 1'b0;
        host_rdata_next  = host_rdata_reg;
        opto_num_next    = opto_num_reg;
        min_out_next     = min_out_reg;
        max_out_next     = max_out_reg;
        scan_done_next   = 1'b0;
        scan_miss_next   = 1'b0;
`ifdef CYCLE_FAULT_CHK_EN
        range_err_next   = range_err_reg;
        fault_next       = fault_reg;
`endif

        if (i_scan_start && scan_active_reg) begin
            scan_miss_next = 1'b1;
        end

        // A start that arrives while a stand-alone host read occupies the
        // port is not busy-time; remember it and begin once back in IDLE.
        if (i_scan_start && !scan_active_reg && state_reg != IDLE) begin
            start_pend_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (i_scan_start || start_pend_reg) begin
                    state_next       = RD_CNT;
                    scan_active_next = 1'b1;
                    start_pend_next  = 1'b0;
                end else if (host_serve) begin
                    state_next = HOST_RD;
                end
            end

            RD_CNT: begin
                state_next = CAP_CNT;
            end

            CAP_CNT: begin
                raw_cnt_next  = i_ram_rdata[CNT_W-1:0];
                last_idx_next = clamped_cnt[RAM_AW-1:0];
                idx_next      = FIRST_ENTRY;
                run_min_next  = '0;
                run_max_next  = '0;
`ifdef CYCLE_FAULT_CHK_EN
                range_err_next = 1'b0;
`endif
                state_next    = (clamped_cnt == '0) ? DONE : RD_ENT;
            end

            RD_ENT: begin
                state_next = CAP_ENT;
            end

            CAP_ENT: begin
                if (idx_reg == FIRST_ENTRY) begin
                    run_min_next = i_ram_rdata;
                    run_max_next = i_ram_rdata;
                end else begin
                    if (i_ram_rdata < run_min_reg) run_min_next = i_ram_rdata;
                    if (i_ram_rdata > run_max_reg) run_max_next = i_ram_rdata;
                end
`ifdef CYCLE_FAULT_CHK_EN
                if (i_ram_rdata < i_cyc_lo || i_ram_rdata > i_cyc_hi) begin
                    range_err_next = 1'b1;
                end
`endif
                // idx advances past the last entry here, so HOST_CAP can tell
                // whether the scan still has entries left.
                idx_next = idx_reg + 1'b1;
                if (host_serve) begin
                    state_next = HOST_RD;
                end else if (idx_reg == last_idx_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = RD_ENT;
                end
            end

            HOST_RD: begin
                state_next = HOST_CAP;
            end

            HOST_CAP: begin
                host_ack_next   = 1'b1;
                host_rdata_next = i_ram_rdata;
                if (!scan_active_reg) begin
                    state_next = IDLE;
                end else if (idx_reg > last_idx_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = RD_ENT;
                end
            end

            DONE: begin
                opto_num_next    = raw_cnt_reg;
                min_out_next     = run_min_reg;
                max_out_next     = run_max_reg;
                scan_done_next   = 1'b1;
                scan_active_next = 1'b0;
`ifdef CYCLE_FAULT_CHK_EN
                fault_next       = range_err_reg || (raw_cnt_reg != i_expect_num);
`endif
                state_next       = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The read port is registered from the state being entered, so the
        // address/enable line up with the RD_* / HOST_RD state itself.
        case (state_next)
            RD_CNT: begin
                ren_next   = 1'b1;
                raddr_next = '0;
            end
            RD_ENT: begin
                ren_next   = 1'b1;
                raddr_next = idx_next;
            end
            HOST_RD: begin
                ren_next   = 1'b1;
                raddr_next = i_host_addr;
            end
            default: begin
                ren_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            scan_active_reg <= 1'b0;
            start_pend_reg  <= 1'b0;
            raw_cnt_reg     <= '0;
            last_idx_reg    <= '0;
            idx_reg         <= '0;
            run_min_reg     <= '0;
            run_max_reg     <= '0;
            raddr_reg       <= '0;
            ren_reg         <= 1'b0;
            host_ack_reg    <= 1'b0;
            host_rdata_reg  <= '0;
            opto_num_reg    <= '0;
            min_out_reg     <= '0;
            max_out_reg     <= '0;
            scan_done_reg   <= 1'b0;
            scan_miss_reg   <= 1'b0;
`ifdef CYCLE_FAULT_CHK_EN
            range_err_reg   <= 1'b0;
            fault_reg       <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            scan_active_reg <= scan_active_next;
            start_pend_reg  <= start_pend_next;
            raw_cnt_reg     <= raw_cnt_next;
            last_idx_reg    <= last_idx_next;
            idx_reg         <= idx_next;
            run_min_reg     <= run_min_next;
            run_max_reg     <= run_max_next;
            raddr_reg       <= raddr_next;
            ren_reg         <= ren_next;
            host_ack_reg    <= host_ack_next;
            host_rdata_reg  <= host_rdata_next;
            opto_num_reg    <= opto_num_next;
            min_out_reg     <= min_out_next;
            max_out_reg     <= max_out_next;
            scan_done_reg   <= scan_done_next;
            scan_miss_reg   <= scan_miss_next;
`ifdef CYCLE_FAULT_CHK_EN
            range_err_reg   <= range_err_next;
            fault_reg       <= fault_next;
`endif
        end
    end

    assign o_host_ack   = host_ack_reg;
    assign o_host_rdata = host_rdata_reg;
    assign o_ram_raddr  = raddr_reg;
    assign o_ram_ren    = ren_reg;
    assign o_opto_num   = opto_num_reg;
    assign o_min_cycle  = min_out_reg;
    assign o_max_cycle  = max_out_reg;
    assign o_scan_busy  = scan_active_reg;
    assign o_scan_done  = scan_done_reg;
    assign o_scan_miss  = scan_miss_reg;
`ifdef CYCLE_FAULT_CHK_EN
    assign o_cycle_fault = fault_reg;
`else
    assign o_cycle_fault = 1'b0;
`endif

endmodule

// File: tb/tb_stat_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stat_scan_ctrl
// Self-checking bench for stat_scan_ctrl. A behavioural RAM answers the read
// port; a reference model derives count/min/max/fault and the expected read
// address sequence straight from the RAM contents. Honours CYCLE_FAULT_CHK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stat_scan_ctrl;

    localparam int LAST = 59;
`ifdef CYCLE_FAULT_CHK_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_start = 1'b0;
    logic        host_req = 1'b0;
    logic [5:0]  host_addr = '0;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic [5:0]  ram_raddr;
    logic        ram_ren;
    logic [31:0] ram_rdata = '0;
    logic [31:0] cyc_lo = '0;
    logic [31:0] cyc_hi = '1;
    logic [7:0]  expect_num = '0;
    logic [7:0]  opto_num;
    logic [31:0] min_cycle, max_cycle;
    logic        scan_busy, scan_done, scan_miss, cycle_fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          done_cnt = 0, ack_cnt = 0, miss_cnt = 0, done_cyc = 0;
    logic [5:0]  ren_q [$];

    logic [7:0]  exp_num;
    logic [31:0] exp_min, exp_max;
    logic        exp_fault;
    int          exp_nc;

    always #10 clk = ~clk;

    stat_scan_ctrl #(.P_LAST_ENTRY(LAST)) dut (
        .i_clk_50m    (clk),
        .i_rst_n      (rst_n),
        .i_scan_start (scan_start),
        .i_host_req   (host_req),
        .i_host_addr  (host_addr),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata),
        .o_ram_raddr  (ram_raddr),
        .o_ram_ren    (ram_ren),
        .i_ram_rdata  (ram_rdata),
        .i_cyc_lo     (cyc_lo),
        .i_cyc_hi     (cyc_hi),
        .i_expect_num (expect_num),
        .o_opto_num   (opto_num),
        .o_min_cycle  (min_cycle),
        .o_max_cycle  (max_cycle),
        .o_scan_busy  (scan_busy),
        .o_scan_done  (scan_done),
        .o_scan_miss  (scan_miss),
        .o_cycle_fault(cycle_fault)
    );

    // Synchronous-read RAM: data one cycle after ren.
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        cyc <= cyc + 1;
    end

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (scan_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (host_ack)  ack_cnt  <= ack_cnt + 1;
        if (scan_miss) miss_cnt <= miss_cnt + 1;
        if (ram_ren)   ren_q.push_back(ram_raddr);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: what a scan of the current RAM contents must report.
    function automatic void model_scan();
        int n;
        logic bad;
        n       = int'(mem[0][7:0]);
        exp_nc  = (n > LAST) ? LAST : n;
        exp_num = mem[0][7:0];
        exp_min = '0;
        exp_max = '0;
        bad     = 1'b0;
        for (int a = 1; a <= exp_nc; a++) begin
            if (a == 1 || mem[a] < exp_min) exp_min = mem[a];
            if (a == 1 || mem[a] > exp_max) exp_max = mem[a];
            if (mem[a] < cyc_lo || mem[a] > cyc_hi) bad = 1'b1;
        end
        exp_fault = FAULT_EN && (bad || (exp_num != expect_num));
    endfunction

    task automatic run_scan(input string tag, input bit with_host, input logic [5:0] haddr);
        int d0, a0, t, lat;
        bit ok;
        logic [5:0] exp_addr [$];
        logic [31:0] exp_hdata;
        model_scan();
        exp_hdata = mem[haddr];
        exp_addr = {};
        exp_addr.push_back(6'd0);
        for (int a = 1; a <= exp_nc; a++) begin
            exp_addr.push_back(6'(a));
            if (with_host && a == 1) exp_addr.push_back(haddr);
        end
        ren_q = {};
        d0 = done_cnt;
        a0 = ack_cnt;
        tick();
        scan_start = 1'b1;
        if (with_host) begin
            host_req  = 1'b1;
            host_addr = haddr;
        end
        tick();
        scan_start = 1'b0;
        lat = cyc;
        t = 0;
        while ((done_cnt == d0 || host_req) && t < 400) begin
            if (host_req && ack_cnt != a0) begin
                checks++;
                if (host_rdata !== exp_hdata) begin
                    errors++;
                    $display("FAIL %s host_rdata: got %h want %h", tag, host_rdata, exp_hdata);
                end
                host_req = 1'b0;
            end else begin
                tick();
                t++;
            end
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL %s timeout: no done within 400 cycles", tag);
        end
        lat = done_cyc - lat;
        checks++;
        if (lat !== 2 * exp_nc + 3 + (with_host ? 2 : 0)) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", tag, lat, 2 * exp_nc + 3 + (with_host ? 2 : 0));
        end
        tick(); tick(); tick();
        checks++;
        if (opto_num !== exp_num || min_cycle !== exp_min || max_cycle !== exp_max) begin
            errors++;
            $display("FAIL %s results: got num=%0d min=%0d max=%0d want num=%0d min=%0d max=%0d",
                     tag, opto_num, min_cycle, max_cycle, exp_num, exp_min, exp_max);
        end
        checks++;
        if (cycle_fault !== exp_fault) begin
            errors++;
            $display("FAIL %s fault: got %b want %b", tag, cycle_fault, exp_fault);
        end
        checks++;
        if (done_cnt - d0 !== 1 || ack_cnt - a0 !== int'(with_host) || scan_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s counts: done=%0d ack=%0d busy=%b want done=1 ack=%0d busy=0",
                     tag, done_cnt - d0, ack_cnt - a0, scan_busy, int'(with_host));
        end
        ok = (ren_q.size() == exp_addr.size());
        for (int i = 0; ok && i < exp_addr.size(); i++) begin
            if (ren_q[i] !== exp_addr[i]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s read_seq: got %0d reads (last %0d) want %0d reads (last %0d)", tag,
                     ren_q.size(), (ren_q.size() > 0) ? ren_q[$] : 6'd0,
                     exp_addr.size(), exp_addr[$]);
        end
        $display("scan %s: num=%0d min=%0d max=%0d fault=%b latency=%0d", tag, opto_num, min_cycle, max_cycle, cycle_fault, lat);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({host_ack, host_rdata, ram_raddr, ram_ren, opto_num, min_cycle, max_cycle,
             scan_busy, scan_done, scan_miss, cycle_fault} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got ack=%b rdata=%h raddr=%0d ren=%b num=%0d min=%0d max=%0d busy=%b done=%b miss=%b fault=%b want all 0",
                     tag, host_ack, host_rdata, ram_raddr, ram_ren, opto_num, min_cycle, max_cycle,
                     scan_busy, scan_done, scan_miss, cycle_fault);
        end
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int a = 1; a < 64; a++) mem[a] = $urandom_range(hi, lo);
    endtask

    task automatic test_reset();
        for (int a = 0; a < 64; a++) mem[a] = '0;
        rst_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        mem[0] = 32'd3; mem[1] = 32'd100; mem[2] = 32'd90; mem[3] = 32'd120;
        expect_num = 8'd3; cyc_lo = 32'd0; cyc_hi = '1;
        run_scan("basic", 1'b0, 6'd0);
        checks++;
        if (min_cycle !== 32'd90 || max_cycle !== 32'd120 || opto_num !== 8'd3) begin
            errors++;
            $display("FAIL basic_const: got min=%0d max=%0d num=%0d want 90/120/3", min_cycle, max_cycle, opto_num);
        end
    endtask

    task automatic test_zero_and_clamp();
        fill_random(1000, 5000);
        mem[0] = 32'hABCDEF00;
        run_scan("zero", 1'b0, 6'd0);
        checks++;
        if (min_cycle !== 32'd0 || max_cycle !== 32'd0 || opto_num !== 8'd0) begin
            errors++;
            $display("FAIL zero_const: got min=%0d max=%0d num=%0d want 0/0/0", min_cycle, max_cycle, opto_num);
        end
        mem[0] = {24'($urandom), 8'd70};
        mem[60] = 32'd1; mem[61] = 32'hFFFF_FFFF; mem[62] = 32'd2; mem[63] = 32'hFFFF_FFF0;
        run_scan("clamp70", 1'b0, 6'd0);
        mem[0] = 32'd59;
        run_scan("exact59", 1'b0, 6'd0);
    endtask

    task automatic test_random_scans();
        for (int k = 0; k < 6; k++) begin
            fill_random(0, 32'hFFFF);
            mem[0] = $urandom_range(20, 1);
            cyc_lo = $urandom_range(2000, 0);
            cyc_hi = $urandom_range(32'hFFFF, 32'hE000);
            expect_num = (k % 2 == 0) ? mem[0][7:0] : 8'($urandom_range(20, 1));
            run_scan($sformatf("rand%0d", k), 1'b0, 6'd0);
        end
    endtask

    task automatic test_host_idle();
        int a0, t;
        logic [5:0] ad;
        for (int k = 0; k < 3; k++) begin
            ad = 6'($urandom_range(63, 0));
            mem[ad] = $urandom;
            a0 = ack_cnt;
            host_addr = ad;
            host_req = 1'b1;
            t = 0;
            while (ack_cnt == a0 && t < 50) begin
                tick();
                t++;
            end
            checks++;
            if (host_rdata !== mem[ad] || t >= 50) begin
                errors++;
                $display("FAIL host_idle_data: got %h want %h (addr %0d, cycles %0d)", host_rdata, mem[ad], ad, t);
            end
            // keep the request up one more cycle: it must not be served again
            tick();
            host_req = 1'b0;
            tick(); tick(); tick();
            checks++;
            if (ack_cnt - a0 !== 1) begin
                errors++;
                $display("FAIL host_idle_acks: got %0d want 1", ack_cnt - a0);
            end
            $display("host idle read: addr=%0d data=%h", ad, host_rdata);
        end
    endtask

    task automatic test_host_during_scan();
        logic [7:0]  n0;
        logic [31:0] mn0, mx0;
        fill_random(500, 9000);
        mem[0] = 32'd8;
        expect_num = 8'd8;
        run_scan("nohost", 1'b0, 6'd5);
        n0 = opto_num; mn0 = min_cycle; mx0 = max_cycle;
        run_scan("withhost", 1'b1, 6'd5);
        checks++;
        if (opto_num !== n0 || min_cycle !== mn0 || max_cycle !== mx0) begin
            errors++;
            $display("FAIL host_scan_same: got %0d/%0d/%0d want %0d/%0d/%0d", opto_num, min_cycle, max_cycle, n0, mn0, mx0);
        end
    endtask

    task automatic test_miss();
        int d0, m0, t;
        fill_random(10, 20000);
        mem[0] = 32'd5;
        model_scan();
        d0 = done_cnt;
        m0 = miss_cnt;
        tick(); scan_start = 1'b1; tick(); scan_start = 1'b0;
        tick(); tick();
        scan_start = 1'b1; tick(); scan_start = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            tick();
            t++;
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (miss_cnt - m0 !== 1 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL miss_counts: got miss=%0d done=%0d want 1/1", miss_cnt - m0, done_cnt - d0);
        end
        checks++;
        if (opto_num !== exp_num || min_cycle !== exp_min || max_cycle !== exp_max) begin
            errors++;
            $display("FAIL miss_results: got %0d/%0d/%0d want %0d/%0d/%0d", opto_num, min_cycle, max_cycle, exp_num, exp_min, exp_max);
        end
        $display("miss: misses=%0d dones=%0d", miss_cnt - m0, done_cnt - d0);
    endtask

    task automatic test_fault();
        logic want;
        mem[0] = 32'd3; mem[1] = 32'd100; mem[2] = 32'd90; mem[3] = 32'd120;
        expect_num = 8'd3; cyc_lo = 32'd95; cyc_hi = 32'd130;
        run_scan("fault_lo95", 1'b0, 6'd0);
        want = FAULT_EN;
        checks++;
        if (cycle_fault !== want) begin
            errors++;
            $display("FAIL fault_lo95_const: got %b want %b", cycle_fault, want);
        end
        cyc_lo = 32'd80;
        run_scan("fault_lo80", 1'b0, 6'd0);
        checks++;
        if (cycle_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_lo80_const: got %b want 0", cycle_fault);
        end
        expect_num = 8'd4;
        run_scan("fault_count", 1'b0, 6'd0);
    endtask

    task automatic test_reset_mid_op();
        int d0, a0;
        fill_random(100, 3000);
        mem[0] = 32'd10;
        expect_num = 8'd1; cyc_lo = 32'd0; cyc_hi = '1;
        run_scan("pre_reset", 1'b0, 6'd0);
        d0 = done_cnt;
        tick(); scan_start = 1'b1; tick(); scan_start = 1'b0;
        tick(); tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_scan");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (done_cnt !== d0 || scan_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%0d busy=%b want 0/0", done_cnt - d0, scan_busy);
        end
        a0 = ack_cnt;
        host_addr = 6'd7;
        host_req = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_host");
        host_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (ack_cnt !== a0) begin
            errors++;
            $display("FAIL reset_no_ack: got %0d acks want 0", ack_cnt - a0);
        end
        $display("reset mid-operation: done=%0d ack=%0d", done_cnt - d0, ack_cnt - a0);
        run_scan("post_reset", 1'b0, 6'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_clamp();
        test_random_scans();
        test_host_idle();
        test_host_during_scan();
        test_miss();
        test_fault();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stat_scan_ctrl.md
STAT_SCAN_CTRL -- requirements
Module: stat_scan_ctrl

Interface
REQ-001 SHALL have parameter P_LAST_ENTRY, default 59; highest interval address scanned.
REQ-002 SHALL have port i_clk_50m  in  1  sole clock.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_scan_start  in  1  single-cycle pulse; revolution complete, start a RAM scan.
REQ-005 SHALL have port i_host_req  in  1  level; host read request, held until o_host_ack.
REQ-006 SHALL have port i_host_addr  in  6  host read address, stable while i_host_req is high.
REQ-007 SHALL have port o_host_ack  out  1  single-cycle pulse; o_host_rdata valid.
REQ-008 SHALL have port o_host_rdata  out  32  host read data, held until the next ack.
REQ-009 SHALL have ports o_ram_raddr  out  6, o_ram_ren  out  1, i_ram_rdata  in  32  cycle-RAM read port; data valid one cycle after ren.
REQ-010 SHALL have ports i_cyc_lo  in  32, i_cyc_hi  in  32, i_expect_num  in  8  fault thresholds.
REQ-011 SHALL have ports o_opto_num  out  8, o_min_cycle  out  32, o_max_cycle  out  32  last completed scan results.
REQ-012 SHALL have ports o_scan_busy  out  1, o_scan_done  out  1 (pulse), o_scan_miss  out  1 (pulse), o_cycle_fault  out  1.

Function
REQ-013 SHALL use FSM states IDLE, RD_CNT, CAP_CNT, RD_ENT, CAP_ENT, HOST_RD, HOST_CAP, DONE.
REQ-014 SHALL, on i_scan_start in IDLE, enter RD_CNT; o_scan_busy high from the next cycle until DONE exits.
REQ-015 SHALL, in RD_CNT, drive raddr 0, ren 1; in CAP_CNT latch i_ram_rdata[7:0] as entry count N.
REQ-016 SHALL clamp N to P_LAST_ENTRY; N=0 skips entries, goes to DONE, min=max=0.
REQ-017 SHALL read addresses 1..N in order, one read (RD_ENT) plus one capture (CAP_ENT) per entry, 2 cycles/entry.
REQ-018 SHALL, in CAP_ENT, update running min/max (first entry initialises both); unsigned 32-bit compare.
REQ-019 SHALL, in DONE, load o_opto_num (unclamped count), o_min_cycle, o_max_cycle and pulse o_scan_done for one cycle, then return to IDLE.
REQ-020 SHALL assert o_ram_ren only in RD_CNT, RD_ENT, HOST_RD; raddr holds its last value otherwise.
REQ-021 SHALL serve a host request from IDLE via HOST_RD (raddr=i_host_addr, ren=1) then HOST_CAP (latch data, pulse ack), then IDLE.
REQ-022 SHALL, during a scan, divert to HOST_RD/HOST_CAP after a CAP_ENT when i_host_req is high, then resume at the next entry; at most one host read per scanned entry.
REQ-023 SHALL give i_scan_start priority over i_host_req when both arrive in IDLE.
REQ-024 SHALL ignore i_scan_start while busy and pulse o_scan_miss the next cycle; results unchanged.
REQ-025 SHALL keep o_host_ack deasserted in the cycle after an ack even if i_host_req is still high.

Reset
REQ-026 SHALL, on i_rst_n low, asynchronously force IDLE and all outputs to 0 (o_ram_raddr 0, ren 0, results 0, flags 0).
REQ-027 SHALL abandon a scan or host read in progress on reset; no ack and no done follow.

Configuration
REQ-028 SHALL implement fault checking only when macro CYCLE_FAULT_CHK_EN is defined.
REQ-029 SHALL, with CYCLE_FAULT_CHK_EN, set o_cycle_fault in DONE when N != i_expect_num or any entry < i_cyc_lo or > i_cyc_hi; hold until the next DONE recomputes it.
REQ-030 SHALL, without CYCLE_FAULT_CHK_EN, tie o_cycle_fault to 0 and leave threshold inputs unused.

Structure
REQ-031 SHALL place FSM state encoding and the constants RAM_AW=6, RAM_DW=32 in shared package stat_scan_pkg.
REQ-032 SHALL be a single module with no sub-modules; RAM instance lives outside.

Verification
REQ-033 SHALL cover: RAM[0]=3, RAM[1..3]=100,90,120, scan_start -> done pulse 9 cycles after start, min=90, max=120, opto_num=3.
REQ-034 SHALL cover: RAM[0]=0 -> done, min=max=0; RAM[0]=70 -> only addresses 1..59 read, opto_num=70.
REQ-035 SHALL cover: host req addr 5 held during scan -> exactly one ack, rdata=RAM[5], scan results unchanged versus no-host run.
REQ-036 SHALL cover: scan_start during busy -> o_scan_miss one pulse, exactly one done.
REQ-037 SHALL cover: with CYCLE_FAULT_CHK_EN, lo=95, hi=130, data of REQ-033 -> fault=1; lo=80 -> fault=0; without macro -> fault=0.
REQ-038 SHALL cover: reset asserted mid-scan -> all outputs 0 immediately, no done after release.
